icache_mem_arbiter: RTL and testbench
=====================================

Name: icache_mem_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ instruction-cache instances share one backing-memory port.
- Each upstream port speaks the caches' existing memory handshake: req/addr held until a ready pulse, with data valid in the ready cycle.
- Only one transaction is in flight at a time. Requests, grants and responses are registered, so there is no combinational path from an upstream req to an upstream ready.

Parameters:
- NUM_REQ, 2, number of requesting caches (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, word width.
- ID_BITS, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- up_req  input  NUM_REQ  per-requester fetch request; bit i belongs to cache i.
- up_addr  input  NUM_REQ*ADDR_WIDTH  per-requester word address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- up_data  output  DATA_WIDTH  response data, broadcast to all requesters.
- up_ready  output  NUM_REQ  one-hot response pulse.
- mem_req  output  1  downstream request.
- mem_addr  output  ADDR_WIDTH  downstream address.
- mem_data  input  DATA_WIDTH  downstream data, valid when mem_ready=1.
- mem_ready  input  1  downstream completion pulse.
- busy  output  1  high while any state other than IDLE is active.
- grant_id  output  ID_BITS  index of the current or last granted requester.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id=0, latched addr=0, latched data=0.
  - up_ready=0, up_data=0, mem_req=0, mem_addr=0, busy=0.
  - Any in-flight transaction is discarded. No up_ready pulse is issued for it, and the downstream request drops immediately.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If up_req != 0, select winner w = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On the edge: grant_id<=w, latch up_addr slice w, go to ISSUE.
  - If up_req == 0, stay in IDLE.
- ISSUE:
  - mem_req=1, mem_addr=latched addr.
  - When mem_ready=1: capture mem_data, go to RESP. Otherwise stay in ISSUE with no limit.
  - Changes on up_req/up_addr in this state are ignored.
- RESP:
  - up_ready[grant_id]=1 for exactly this one cycle; all other bits are 0.
  - up_data=captured data.
  - On the edge: rr_ptr <= grant_id+1, wrapping NUM_REQ-1 -> 0. Go to IDLE.
- Output rules:
  - up_data holds its last captured value outside RESP.
  - mem_addr=0 outside ISSUE.
  - mem_req is a pure decode of state==ISSUE.
  - up_ready is a pure decode of state==RESP && grant_id.
- Latency:
  - up_req seen in IDLE at cycle T -> mem_req high from T+1.
  - mem_ready at cycle T+1+k (k>=0) -> up_ready pulse at T+2+k.
  - Minimum 3 cycles from request to response, excluding the cache's own cycles.
- Requester contract: hold up_req and up_addr stable until your up_ready pulse. The cache drops req in the cycle after ready, so the arbiter sees it low on return to IDLE.
- Boundary cases:
  - mem_ready while in IDLE or RESP is ignored.
  - Simultaneous requests resolve by rr_ptr order, so any continuously requesting port waits at most NUM_REQ-1 transactions.
  - A request that arrives during ISSUE or RESP waits in IDLE arbitration.
  - A requester that drops up_req before its grant is simply not selected.
  - Back-to-back requests: IDLE is visited for one cycle between transactions, so there is no idle gap beyond that cycle.

Test Plan:
- Single request: reset, up_req=01, addr0=0x0000_1040, mem_ready pulses 2 cycles after mem_req rises with mem_data=0xDEAD_BEEF -> mem_addr=0x1040 while mem_req; up_ready=01 for one cycle with up_data=0xDEADBEEF; busy high exactly from grant to RESP.
- Contention fairness: both requesters high from reset, addr0=0x100, addr1=0x200, mem_ready one cycle after every mem_req -> mem_addr sequence 0x100, 0x200, 0x100, 0x200; up_ready alternates 01, 10; grant_id alternates 0, 1.
- Pointer wrap, NUM_REQ=4: only port 3 requests, then ports 0 and 3 request together -> port 3 served first, then port 0 (rr_ptr wraps to 0); never port 3 twice in a row while port 0 waits.
- Stray mem_ready in IDLE with up_req=0 -> no state change, up_ready=0, up_data unchanged.
- Reset mid-ISSUE: assert rst_n=0 while mem_req=1 -> mem_req drops at once, no up_ready pulse; after release a fresh request from port 1 is granted with rr_ptr=0 ordering.
- Long stall: mem_ready held low for 50 cycles -> mem_req/mem_addr held constant, up_ready stays 0, and no other grant occurs.

Source files
------------

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter: round-robin sharing of one backing-memory port among
// NUM_REQ instruction caches. One transaction in flight at a time; every
// output is a decode of registered state, so upstream req never reaches
// upstream ready combinationally.
module icache_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            up_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] up_addr,
  output logic [DATA_WIDTH-1:0]         up_data,
  output logic [NUM_REQ-1:0]            up_ready,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [ID_BITS-1:0]            grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ID_BITS-1:0]    r_rr_ptr;
  logic [ID_BITS-1:0]    r_grant_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic                  w_found;
  logic [ID_BITS-1:0]    w_winner;
  logic [ID_BITS-1:0]    w_grant_inc;

  // Unpack the flat address bus and decode the one-hot ready per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign w_addr_arr[gi] = up_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign up_ready[gi]   = (r_state == ST_RESP) && (r_grant_id == ID_BITS'(gi));
    end
  endgenerate

  // Rotating priority search starting at r_rr_ptr. Iterating from the far end
  // back toward offset 0 lets the closest requester overwrite the others.
  always_comb begin
    logic [ID_BITS:0] v_sum;
    w_found  = 1'b0;
    w_winner = '0;
    v_sum    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      v_sum = {1'b0, r_rr_ptr} + (ID_BITS+1)'(off);
      if (v_sum >= (ID_BITS+1)'(NUM_REQ)) begin
        v_sum = v_sum - (ID_BITS+1)'(NUM_REQ);
      end
      if (up_req[v_sum[ID_BITS-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_sum[ID_BITS-1:0];
      end
    end
  end

  // Pointer advances past the requester just served, wrapping at NUM_REQ.
  assign w_grant_inc = (r_grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  // Transaction FSM: arbitrate in IDLE, hold the memory request in ISSUE,
  // present the captured word for one cycle in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_addr     <= w_addr_arr[w_winner];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            r_data  <= mem_data;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_rr_ptr <= w_grant_inc;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req  = (r_state == ST_ISSUE);
  assign mem_addr = (r_state == ST_ISSUE) ? r_addr : '0;
  assign up_data  = r_data;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Randomized bench for icache_mem_arbiter (NUM_REQ=4). A transaction-level
// reference model predicts grants and responses from the stimulus; a separate
// monitor compares the DUT against it on the falling edge.
module tb_icache_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    up_req = '0;
  logic [AW-1:0]   drv_addr [N];
  logic [N*AW-1:0] up_addr;
  logic [DW-1:0]   up_data;
  logic [N-1:0]    up_ready;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data = '0;
  logic            mem_ready = 1'b0;
  logic            busy;
  logic [IB-1:0]   grant_id;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_addr
    assign up_addr[gi*AW +: AW] = drv_addr[gi];
  end

  icache_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_BITS(IB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req(up_req), .up_addr(up_addr),
    .up_data(up_data), .up_ready(up_ready),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [IB-1:0] port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q [$];
  bit            m_active = 0;   // a transaction has been granted
  bit            m_resp   = 0;   // its memory word has arrived
  int            m_ptr    = 0;   // first port to consider next arbitration
  logic [IB-1:0] m_port   = '0;
  logic [IB-1:0] m_p;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_data   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_resp = 0; m_ptr = 0;
      m_port = '0; m_addr = '0; m_data = '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (up_req != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          m_p = IB'((m_ptr + k) % N);
          if (up_req[m_p]) m_port = m_p;
        end
        m_addr   = drv_addr[m_port];
        m_active = 1;
      end
    end else if (!m_resp) begin
      if (mem_ready) begin
        m_data = mem_data;
        m_resp = 1;
        exp_q.push_back('{port: m_port, data: mem_data});
      end
    end else begin
      m_ptr    = (int'(m_port) + 1) % N;
      m_active = 0;
      m_resp   = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    resp_t        r;
    if (!rst_n) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_up_ready", up_ready, 0);
      check("rst_up_data", up_data, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
    end else begin
      e_rdy = '0;
      if (m_resp) e_rdy[m_port] = 1'b1;
      check("mem_req", mem_req, (m_active && !m_resp));
      check("mem_addr", mem_addr, (m_active && !m_resp) ? m_addr : '0);
      check("busy", busy, m_active);
      check("grant_id", grant_id, m_port);
      check("up_data_hold", up_data, m_data);
      check("up_ready", up_ready, e_rdy);
      if (up_ready != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_up_ready", up_ready, 0);
        end else begin
          r = exp_q.pop_front();
          n_resp++;
          $display("[TB] resp port=%0d data=0x%08h up_ready=%b", r.port, up_data, up_ready);
          check("resp_port", up_ready, N'(1) << r.port);
          check("resp_data", up_data, r.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0]  cfg_mask  = '0;
  int            cfg_pct   = 0;
  bit            cfg_raddr = 0;
  int            cfg_dmin  = 0;
  int            cfg_dmax  = 0;
  bit            cfg_stray = 0;
  bit            cfg_fdata = 0;
  logic [DW-1:0] cfg_data  = '0;
  int            mcnt      = -1;
  logic [IB-1:0] d_p;

  // One clock of requester and memory behaviour, driven just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      d_p = IB'(i);
      if (up_req[d_p] && up_ready[d_p]) begin
        up_req[d_p] = 1'b0;
      end else if (!up_req[d_p]) begin
        if (cfg_raddr) drv_addr[d_p] = $urandom;
        if (cfg_mask[d_p] && ($urandom_range(99) < cfg_pct)) up_req[d_p] = 1'b1;
      end
    end
    mem_ready = 1'b0;
    mem_data  = $urandom;
    if (mem_req) begin
      if (mcnt < 0) mcnt = $urandom_range(cfg_dmax, cfg_dmin);
      if (mcnt == 0) begin
        mem_ready = 1'b1;
        mem_data  = cfg_fdata ? cfg_data : $urandom;
        mcnt      = -1;
      end else begin
        mcnt--;
      end
    end else begin
      mcnt = -1;
      if (cfg_stray && ($urandom_range(3) == 0)) mem_ready = 1'b1;
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < N; i++) drv_addr[i] = AW'(32'h100 * (i + 1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, fixed address/data, two-cycle memory delay.
    drv_addr[0] = 32'h0000_1040;
    cfg_mask = 4'b0001; cfg_pct = 100; cfg_dmin = 2; cfg_dmax = 2;
    cfg_fdata = 1; cfg_data = 32'hDEAD_BEEF;
    run(16);

    // Two requesters contending continuously, memory answers at once.
    cfg_fdata = 0;
    drv_addr[0] = 32'h100; drv_addr[1] = 32'h200;
    cfg_mask = 4'b0011; cfg_dmin = 0; cfg_dmax = 0;
    run(24);
    cfg_mask = 4'b0000;
    run(8);

    // Pointer wrap: port 3 alone, then ports 0 and 3 together.
    cfg_mask = 4'b1000;
    run(8);
    cfg_mask = 4'b1001;
    run(24);
    cfg_mask = 4'b0000;
    run(8);

    // Stray mem_ready pulses with nothing requesting.
    cfg_stray = 1;
    run(20);
    cfg_stray = 0;

    // Reset while a transaction waits on memory.
    cfg_mask = 4'b0001; cfg_dmin = 30; cfg_dmax = 30;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (mem_req) seen = 1;
    end
    check("wait_mem_req_before_reset", seen, 1);
    run(3);
    @(posedge clk);
    #1;
    rst_n = 1'b0; up_req = '0; mem_ready = 1'b0; mcnt = -1; cfg_mask = '0;
    #1;
    check("async_reset_mem_req", mem_req, 0);
    check("async_reset_up_ready", up_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_mask = 4'b0110; cfg_dmin = 0; cfg_dmax = 1;
    run(20);
    cfg_mask = 4'b0000;
    run(8);

    // Long memory stall.
    cfg_mask = 4'b1111; cfg_pct = 50; cfg_raddr = 1; cfg_dmin = 50; cfg_dmax = 50;
    run(120);
    cfg_mask = 4'b0000;
    run(60);

    // Random traffic on all ports.
    cfg_mask = 4'b1111; cfg_pct = 30; cfg_dmin = 0; cfg_dmax = 4; cfg_stray = 1;
    run(600);
    cfg_mask = 4'b0000; cfg_stray = 0;
    run(40);

    check("scoreboard_drained", exp_q.size(), 0);
    check("responses_seen", (n_resp >= 40), 1);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
